udc_bus_sequencer: RTL

- Command-driven bus master that sequences the up/down counter (UDC) through its chip-select/strobe register interface (din, ncs, nrd, nwr, a0, a1, start) and collects its status (cout, err, dir, ec).
- Converts single-cycle host commands (write register, read count, start pulse, nop) into correctly timed bus cycles and returns one response per command.
- Sits between a test/control master and the UDC; it is the only driver of the UDC bus.

---
 rtl/udc_bus_sequencer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/udc_bus_sequencer.sv
// Bus master that turns single-cycle host commands into timed UDC register bus cycles.
// Optional sticky error gating is enabled by defining UDC_SEQ_STICKY_ERR_EN.
module udc_bus_sequencer #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned COUT_W     = 8,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned START_CYC  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [1:0]        cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [COUT_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_dir,
  output logic              busy,
  output logic [DATA_W-1:0] udc_din,
  output logic              udc_ncs,
  output logic              udc_nrd,
  output logic              udc_nwr,
  output logic              udc_a0,
  output logic              udc_a1,
  output logic              udc_start,
  input  logic [COUT_W-1:0] udc_cout,
  input  logic              udc_err,
  input  logic              udc_dir,
  input  logic              udc_ec
`ifdef UDC_SEQ_STICKY_ERR_EN
  ,
  output logic              sticky_err
`endif
);

  localparam logic [1:0] OpWrite = 2'b00;
  localparam logic [1:0] OpRead  = 2'b01;
  localparam logic [1:0] OpStart = 2'b10;

  // Phase counter counts down from (length - 1) so the last cycle of a phase is cnt_q == 0.
  localparam logic [3:0] SetupLd  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] StrobeLd = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HoldLd   = 4'(HOLD_CYC - 1);
  localparam logic [3:0] StartLd  = 4'(START_CYC - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StStartP, StResp} state_e;

  state_e              state_q;
  logic [3:0]          cnt_q;
  logic [1:0]          op_q;
  logic [COUT_W-1:0]   cap_rdata_q;
  logic                cap_err_q;
  logic                cap_dir_q;
  logic                skip_cmd;
  logic                sticky_q;
  logic                unused_ec;

  assign unused_ec = udc_ec;

`ifdef UDC_SEQ_STICKY_ERR_EN
  assign skip_cmd   = sticky_q && ((cmd_op == OpWrite) || (cmd_op == OpStart));
  assign sticky_err = sticky_q;
`else
  assign skip_cmd   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      op_q        <= '0;
      cap_rdata_q <= '0;
      cap_err_q   <= 1'b0;
      cap_dir_q   <= 1'b0;
      sticky_q    <= 1'b0;
      cmd_ready   <= 1'b0;
      busy        <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_dir     <= 1'b0;
      udc_din     <= '0;
      udc_ncs     <= 1'b1;
      udc_nrd     <= 1'b1;
      udc_nwr     <= 1'b1;
      udc_a0      <= 1'b0;
      udc_a1      <= 1'b0;
      udc_start   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            op_q      <= cmd_op;
            if (skip_cmd) begin
              // Gated write/start: no bus activity, immediate error response.
              state_q   <= StResp;
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
              rsp_err   <= 1'b1;
              rsp_dir   <= udc_dir;
            end else begin
              unique case (cmd_op)
                OpWrite, OpRead: begin
                  state_q <= StSetup;
                  cnt_q   <= SetupLd;
                  udc_ncs <= 1'b0;
                  udc_a1  <= cmd_addr[1];
                  udc_a0  <= cmd_addr[0];
                  udc_din <= (cmd_op == OpWrite) ? cmd_wdata : '0;
                end
                OpStart: begin
                  state_q   <= StStartP;
                  cnt_q     <= StartLd;
                  udc_start <= 1'b1;
                end
                default: begin
                  state_q   <= StResp;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b0;
                  rsp_dir   <= udc_dir;
                  if (cmd_wdata[0]) sticky_q <= 1'b0;
                end
              endcase
            end
          end
        end
        StSetup: begin
          if (cnt_q == 4'd0) begin
            state_q <= StStrobe;
            cnt_q   <= StrobeLd;
            if (op_q == OpWrite) udc_nwr <= 1'b0;
            else                 udc_nrd <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StStrobe: begin
          if (cnt_q == 4'd0) begin
            state_q     <= StHold;
            cnt_q       <= HoldLd;
            udc_nwr     <= 1'b1;
            udc_nrd     <= 1'b1;
            cap_rdata_q <= (op_q == OpRead) ? udc_cout : '0;
            cap_err_q   <= udc_err;
            cap_dir_q   <= udc_dir;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StHold: begin
          if (cnt_q == 4'd0) begin
            state_q   <= StResp;
            udc_ncs   <= 1'b1;
            udc_din   <= '0;
            udc_a0    <= 1'b0;
            udc_a1    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= cap_rdata_q;
            rsp_err   <= cap_err_q;
            rsp_dir   <= cap_dir_q;
            if (cap_err_q) sticky_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StStartP: begin
          if (cnt_q == 4'd0) begin
            state_q   <= StResp;
            udc_start <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= udc_err;
            rsp_dir   <= udc_dir;
            if (udc_err) sticky_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          state_q   <= StIdle;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
